// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter
// Shares the single data-memory port between the CPU data side (port A,
// fixed priority) and the DMA/host loader (port B). A starvation counter
// forces a B grant after STARVE_LIMIT consecutive refusals, and a bounded
// burst lock lets B own the port for up to MAX_BURST consecutive cycles.
// Grants are combinational in the request cycle; read data returns one
// cycle later, tagged to the port that issued the read.

module dm_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8,   // 1..255
  parameter int unsigned MAX_BURST    = 16   // 1..255
) (
  input  logic        clk,
  input  logic        rst,            // synchronous, active-low

  // Port A: CPU data side
  input  logic        a_req,
  input  logic [3:0]  a_w_en,
  input  logic [15:0] a_address,
  input  logic [31:0] a_write_data,
  output logic        a_gnt,
  output logic        a_rvalid,
  output logic [31:0] a_read_data,

  // Port B: DMA / host loader
  input  logic        b_req,
  input  logic [3:0]  b_w_en,
  input  logic [15:0] b_address,
  input  logic [31:0] b_write_data,
  input  logic        b_lock,
  output logic        b_gnt,
  output logic        b_rvalid,
  output logic [31:0] b_read_data,

  // Data-memory macro
  output logic [15:0] dm_address,
  output logic [3:0]  dm_w_en,
  output logic [31:0] dm_write_data,
  input  logic [31:0] dm_read_data
);

  // Counter thresholds in the counters' own 8-bit width.
  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);
  localparam logic [7:0] BURST_MAX  = 8'(MAX_BURST);
  // A one-beat burst is indistinguishable from a plain grant, so the burst
  // state is only ever entered when more than one beat is allowed.
  localparam bit         BURST_EN   = (MAX_BURST > 1);

  typedef enum logic [0:0] {
    ARB     = 1'b0,   // normal arbitration, A has priority
    B_BURST = 1'b1    // B owns the port while it keeps b_lock asserted
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] starve_q, starve_d;
  logic [7:0] burst_q, burst_d;
  logic [7:0] burst_inc;
  logic       grant_a, grant_b;
  logic       a_rvalid_q, b_rvalid_q;

  assign burst_inc = burst_q + 8'd1;

  // Grant decision: combinational in the request cycle, suppressed in reset.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; a missing default would infer a latch.
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (rst) begin
      unique case (state_q)
        ARB: begin
          if (b_req && (starve_q >= STARVE_MAX)) begin
            grant_b = 1'b1;
          end else if (a_req) begin
            grant_a = 1'b1;
          end else if (b_req) begin
            grant_b = 1'b1;
          end
        end
        B_BURST: begin
          // A is locked out; B is served only while it still asks for the lock.
          if (b_req && b_lock) begin
            grant_b = 1'b1;
          end
        end
        default: begin
          grant_a = 1'b0;
          grant_b = 1'b0;
        end
      endcase
    end
  end

  // Next-state, starvation counter and burst counter update.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    burst_d  = burst_q;
    unique case (state_q)
      ARB: begin
        // Count consecutive refused B cycles, saturating at the limit.
        if (b_req && !grant_b) begin
          starve_d = (starve_q >= STARVE_MAX) ? STARVE_MAX : starve_q + 8'd1;
        end else begin
          starve_d = 8'd0;
        end
        if (grant_b && b_lock && BURST_EN) begin
          state_d = B_BURST;
          burst_d = 8'd1;
        end
      end
      B_BURST: begin
        starve_d = 8'd0;
        if (grant_b) begin
          if (burst_inc >= BURST_MAX) begin
            state_d = ARB;
            burst_d = 8'd0;
          end else begin
            burst_d = burst_inc;
          end
        end else begin
          // Lock or request dropped: leave without granting this cycle.
          state_d = ARB;
          burst_d = 8'd0;
        end
      end
      default: begin
        state_d  = ARB;
        starve_d = 8'd0;
        burst_d  = 8'd0;
      end
    endcase
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst) begin
      state_q  <= ARB;
      starve_q <= 8'd0;
      burst_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      burst_q  <= burst_d;
    end
  end

  // Read-return owner tag: a granted access with no byte enables is a read,
  // and its data comes back from the macro on the following cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      a_rvalid_q <= grant_a && (a_w_en == 4'b0000);
      b_rvalid_q <= grant_b && (b_w_en == 4'b0000);
    end
  end

  // Memory-side mux: B only when granted; otherwise A's address and data sit
  // on the bus with byte enables forced off unless A is granted.
  assign dm_address    = grant_b ? b_address    : a_address;
  assign dm_write_data = grant_b ? b_write_data : a_write_data;
  assign dm_w_en       = grant_b ? b_w_en : (grant_a ? a_w_en : 4'b0000);

  assign a_gnt       = grant_a;
  assign b_gnt       = grant_b;
  assign a_rvalid    = a_rvalid_q;
  assign b_rvalid    = b_rvalid_q;
  assign a_read_data = dm_read_data;
  assign b_read_data = dm_read_data;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter with a behavioural data memory.
// Inputs change 1 time unit after a rising edge; outputs are compared
// 1 time unit later, well before the next edge.

module tb_dm_port_arbiter;

  logic        clk;
  logic        rst;
  logic        a_req, b_req, b_lock;
  logic [3:0]  a_w_en, b_w_en;
  logic [15:0] a_address, b_address;
  logic [31:0] a_write_data, b_write_data;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [31:0] a_read_data, b_read_data;
  logic [15:0] dm_address;
  logic [3:0]  dm_w_en;
  logic [31:0] dm_write_data;
  logic [31:0] dm_read_data;

  int n_checks = 0;
  int n_fail   = 0;

  dm_port_arbiter #(.STARVE_LIMIT(8), .MAX_BURST(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .a_req        (a_req),
    .a_w_en       (a_w_en),
    .a_address    (a_address),
    .a_write_data (a_write_data),
    .a_gnt        (a_gnt),
    .a_rvalid     (a_rvalid),
    .a_read_data  (a_read_data),
    .b_req        (b_req),
    .b_w_en       (b_w_en),
    .b_address    (b_address),
    .b_write_data (b_write_data),
    .b_lock       (b_lock),
    .b_gnt        (b_gnt),
    .b_rvalid     (b_rvalid),
    .b_read_data  (b_read_data),
    .dm_address   (dm_address),
    .dm_w_en      (dm_w_en),
    .dm_write_data(dm_write_data),
    .dm_read_data (dm_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Default contents of a never-written word.
  function automatic logic [31:0] pat(int idx);
    return 32'h5A5A0000 + 32'(idx);
  endfunction

  // Behavioural memory: registered read, byte-enabled write.
  logic [31:0] mem [0:16383];
  bit          vld [0:16383];
  always @(posedge clk) begin
    logic [31:0] cur;
    int          idx;
    idx = int'(dm_address[15:2]);
    cur = vld[idx] ? mem[idx] : pat(idx);
    dm_read_data <= cur;
    if (dm_w_en != 4'b0000) begin
      for (int i = 0; i < 4; i++)
        if (dm_w_en[i]) cur[8*i +: 8] = dm_write_data[8*i +: 8];
      mem[idx] <= cur;
      vld[idx] <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_req = 1'b0; b_req = 1'b0; b_lock = 1'b0;
    a_w_en = 4'b0000; b_w_en = 4'b0000;
  endtask

  initial begin
    rst = 1'b0;
    a_req = 1'b1; b_req = 1'b1; b_lock = 1'b0;
    a_w_en = 4'hF; b_w_en = 4'hF;
    a_address = 16'h0000; b_address = 16'h0000;
    a_write_data = 32'h0; b_write_data = 32'h0;

    // ---- Reset held for two cycles with both ports requesting writes
    for (int c = 0; c < 2; c++) begin
      tick();
      check("rst_a_gnt", 32'(a_gnt), 32'd0);
      check("rst_b_gnt", 32'(b_gnt), 32'd0);
      check("rst_dm_w_en", 32'(dm_w_en), 32'd0);
      check("rst_a_rvalid", 32'(a_rvalid), 32'd0);
      check("rst_b_rvalid", 32'(b_rvalid), 32'd0);
    end

    // ---- Release: A reads 0x105C while B also requests
    rst = 1'b1;
    a_w_en = 4'b0000; a_address = 16'h105C;
    b_w_en = 4'b0000; b_address = 16'h0100;
    #1;
    check("prio_a_gnt", 32'(a_gnt), 32'd1);
    check("prio_b_gnt", 32'(b_gnt), 32'd0);
    check("prio_dm_addr", 32'(dm_address), 32'h105C);
    check("prio_dm_w_en", 32'(dm_w_en), 32'd0);
    tick();
    a_req = 1'b0; b_req = 1'b0;
    #1;
    check("prio_a_rvalid", 32'(a_rvalid), 32'd1);
    check("prio_a_rdata", a_read_data, pat(16'h105C >> 2));
    check("prio_b_rvalid", 32'(b_rvalid), 32'd0);
    check("idle_gnt", 32'({a_gnt, b_gnt}), 32'd0);
    check("idle_dm_w_en", 32'(dm_w_en), 32'd0);
    check("idle_dm_addr", 32'(dm_address), 32'h105C);
    tick();

    // ---- Starvation: A held, B requesting from cycle 0
    a_address = 16'h0010; b_address = 16'h0020;
    for (int c = 0; c < 10; c++) begin
      a_req = 1'b1;
      b_req = (c <= 8);
      #1;
      check($sformatf("starve_b_gnt_c%0d", c), 32'(b_gnt), 32'(c == 8));
      check($sformatf("starve_a_gnt_c%0d", c), 32'(a_gnt), 32'(c != 8));
      if (c == 1) check("starve_a_rvalid_c1", 32'(a_rvalid), 32'd1);
      if (c == 9) begin
        check("starve_b_rvalid_c9", 32'(b_rvalid), 32'd1);
        check("starve_a_rvalid_c9", 32'(a_rvalid), 32'd0);
        check("starve_b_rdata", b_read_data, pat(16'h0020 >> 2));
      end
      tick();
    end
    idle();
    tick();

    // ---- Full 16-beat locked write burst, A requesting from beat 1
    for (int k = 0; k < 16; k++) begin
      a_req = (k != 0);
      a_w_en = 4'b0000; a_address = 16'h203C;
      b_req = 1'b1; b_lock = 1'b1; b_w_en = 4'hF;
      b_address = 16'h2000 + 16'(4 * k);
      b_write_data = 32'hD0000000 + 32'(k);
      #1;
      check($sformatf("burst_b_gnt_%0d", k), 32'(b_gnt), 32'd1);
      check($sformatf("burst_a_gnt_%0d", k), 32'(a_gnt), 32'd0);
      if (k == 15) begin
        check("burst_dm_addr_15", 32'(dm_address), 32'h203C);
        check("burst_dm_w_en_15", 32'(dm_w_en), 32'hF);
      end
      tick();
    end
    // After 16 beats the lock expires and A gets in (reads the last word).
    b_req = 1'b0; b_lock = 1'b0;
    #1;
    check("burst_end_a_gnt", 32'(a_gnt), 32'd1);
    check("burst_end_b_gnt", 32'(b_gnt), 32'd0);
    tick();
    idle();
    #1;
    check("burst_rb_rvalid", 32'(a_rvalid), 32'd1);
    check("burst_rb_data", a_read_data, 32'hD000000F);
    tick();

    // ---- Burst with b_lock dropped at the 5th beat
    for (int k = 0; k < 5; k++) begin
      a_req = (k != 0);
      b_req = 1'b1; b_lock = (k != 4); b_w_en = 4'hF;
      b_address = 16'h3000 + 16'(4 * k);
      b_write_data = 32'hE0000000 + 32'(k);
      #1;
      if (k < 4) begin
        check($sformatf("lock_b_gnt_%0d", k), 32'(b_gnt), 32'd1);
      end else begin
        check("lock_drop_gnt", 32'({a_gnt, b_gnt}), 32'd0);
        check("lock_drop_w_en", 32'(dm_w_en), 32'd0);
      end
      tick();
    end
    #1;
    check("lock_next_a_gnt", 32'(a_gnt), 32'd1);
    check("lock_next_b_gnt", 32'(b_gnt), 32'd0);
    tick();
    idle();
    tick();

    // ---- Interleaved reads A then B, then a byte write and readback
    a_req = 1'b1; a_w_en = 4'b0000; a_address = 16'h0000;
    #1;
    check("intl_a_gnt", 32'(a_gnt), 32'd1);
    tick();
    a_req = 1'b0;
    b_req = 1'b1; b_w_en = 4'b0000; b_address = 16'h0004;
    #1;
    check("intl_b_gnt", 32'(b_gnt), 32'd1);
    check("intl_a_rvalid", 32'(a_rvalid), 32'd1);
    check("intl_b_rvalid0", 32'(b_rvalid), 32'd0);
    check("intl_a_rdata", a_read_data, pat(0));
    tick();
    b_req = 1'b0;
    a_req = 1'b1; a_w_en = 4'b0010; a_address = 16'h0008;
    a_write_data = 32'h11223344;
    #1;
    check("intl_b_rvalid", 32'(b_rvalid), 32'd1);
    check("intl_a_rvalid0", 32'(a_rvalid), 32'd0);
    check("intl_b_rdata", b_read_data, pat(1));
    check("bytew_dm_w_en", 32'(dm_w_en), 32'b0010);
    tick();
    a_w_en = 4'b0000;
    #1;
    check("bytew_no_rvalid", 32'(a_rvalid), 32'd0);
    tick();
    a_req = 1'b0;
    #1;
    check("bytew_rb_rvalid", 32'(a_rvalid), 32'd1);
    check("bytew_rb_data", a_read_data, (pat(2) & 32'hFFFF00FF) | 32'h00003300);
    tick();

    // ---- Reset asserted at the 3rd burst beat
    for (int k = 0; k < 2; k++) begin
      a_req = (k != 0);
      b_req = 1'b1; b_lock = 1'b1; b_w_en = 4'hF;
      b_address = 16'h4000 + 16'(4 * k);
      #1;
      check($sformatf("rburst_b_gnt_%0d", k), 32'(b_gnt), 32'd1);
      tick();
    end
    rst = 1'b0;
    b_w_en = 4'b0000;   // a read attempted in the reset cycle
    #1;
    check("rburst_rst_gnt", 32'({a_gnt, b_gnt}), 32'd0);
    check("rburst_rst_w_en", 32'(dm_w_en), 32'd0);
    tick();
    rst = 1'b1;
    a_req = 1'b1; b_req = 1'b1; b_lock = 1'b1;
    #1;
    check("rburst_a_gnt", 32'(a_gnt), 32'd1);
    check("rburst_b_gnt", 32'(b_gnt), 32'd0);
    check("rburst_b_rvalid", 32'(b_rvalid), 32'd0);
    tick();
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
